// File: rtl/parity_arb_seq_if.sv
// Handshake bundle for parity_arb_seq: two requester channels and one result channel.
// The DUT connects through the slave modport and the driving side through master.
interface parity_arb_seq_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         req0_valid;
    logic [W-1:0] req0_data;
    logic         req0_ready;
    logic         req1_valid;
    logic [W-1:0] req1_data;
    logic         req1_ready;
    logic         res_valid;
    logic         res_ready;
    logic         res_id;
    logic         res_parity;
    logic [7:0]   res_count;

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, res_ready,
        output req0_ready, req1_ready, res_valid, res_id, res_parity, res_count
    );

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, res_ready,
        input  req0_ready, req1_ready, res_valid, res_id, res_parity, res_count
    );
endinterface

// File: rtl/parity_arb_seq.sv
// Two-requester round-robin arbiter feeding one shared 4-input parity evaluator,
// which folds the accepted word one nibble per cycle into a registered result.
module parity_arb_seq #(
    parameter int NIBBLES = 4
) (
    input  logic            clk,
    input  logic            aresetn,
    parity_arb_seq_if.slave bus
);
    localparam int W = 4 * NIBBLES;

    typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

    state_t       state, state_nx;
    logic [W-1:0] data_q;
    logic         id_q;
    logic         last_grant;
    logic [3:0]   cnt;
    logic         acc;
    logic         res_id_q;
    logic         res_parity_q;
    logic [7:0]   res_count_q;

    logic         grant_any;
    logic         grant_id;
    logic         last_nibble;
    logic         handshake;
    logic [3:0]   nib;
    logic         nib_par;

    // Grant is gated by aresetn so neither ready can be seen while reset is held.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        grant_any = 1'b0;
        grant_id  = 1'b0;
        if (state == IDLE && aresetn) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant_any = 1'b1;
                grant_id  = ~last_grant;
            end else if (bus.req0_valid) begin
                grant_any = 1'b1;
            end else if (bus.req1_valid) begin
                grant_any = 1'b1;
                grant_id  = 1'b1;
            end
        end
    end

    assign bus.req0_ready = grant_any && !grant_id;
    assign bus.req1_ready = grant_any && grant_id;

    always_comb begin
        nib = 4'h0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (cnt == 4'(i)) nib = data_q[4*i +: 4];
        end
    end

    // The single shared evaluator.
    assign nib_par     = nib[0] ^ nib[1] ^ nib[2] ^ nib[3];
    assign last_nibble = (state == EVAL) && (cnt == 4'(NIBBLES - 1));
    assign handshake   = (state == DONE) && bus.res_ready;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant_any)   state_nx = EVAL;
            EVAL:    if (last_nibble) state_nx = DONE;
            DONE:    if (handshake)   state_nx = IDLE;
            default:                  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            data_q       <= '0;
            id_q         <= 1'b0;
            last_grant   <= 1'b1;
            cnt          <= 4'h0;
            acc          <= 1'b0;
            res_id_q     <= 1'b0;
            res_parity_q <= 1'b0;
            res_count_q  <= 8'h00;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            if (grant_any) begin
                data_q     <= grant_id ? bus.req1_data : bus.req0_data;
                id_q       <= grant_id;
                last_grant <= grant_id;
                cnt        <= 4'h0;
                acc        <= 1'b0;
            end else if (state == EVAL) begin
                acc <= acc ^ nib_par;
                cnt <= cnt + 4'h1;
                if (last_nibble) begin
                    res_parity_q <= acc ^ nib_par;
                    res_id_q     <= id_q;
                end
            end
            if (handshake) res_count_q <= res_count_q + 8'h01;
        end
    end

    assign bus.res_valid  = (state == DONE);
    assign bus.res_id     = res_id_q;
    assign bus.res_parity = res_parity_q;
    assign bus.res_count  = res_count_q;
endmodule

// File: tb/tb_parity_arb_seq.sv
// Directed self-checking bench for parity_arb_seq: reset, single requests,
// contention, backpressure, mid-operation reset and result-counter wrap.
module tb_parity_arb_seq;
    localparam int NIBBLES = 4;

    logic clk = 1'b0;
    logic aresetn;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    parity_arb_seq_if #(.NIBBLES(NIBBLES)) bus ();

    parity_arb_seq #(.NIBBLES(NIBBLES)) dut (
        .clk     (clk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        aresetn        = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.res_ready  = 1'b0;
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
    endtask

    // One complete transaction on requester id; flips bit 0 of the held data right after acceptance when toggle is set.
    task automatic run_txn(input bit id, input logic [15:0] data, input bit toggle,
                           output int lat, output bit got_id, output bit got_par, output bit tmo);
        bit seen = 1'b0;
        tmo = 1'b0;
        @(negedge clk);
        bus.res_ready = 1'b0;
        if (id) begin bus.req1_valid = 1'b1; bus.req1_data = data; end
        else    begin bus.req0_valid = 1'b1; bus.req0_data = data; end
        for (int k = 0; k < 20; k++) begin
            #1;
            if ((id ? bus.req1_ready : bus.req0_ready) === 1'b1) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        if (!seen) tmo = 1'b1;
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        if (toggle) begin
            if (id) bus.req1_data = data ^ 16'h0001;
            else    bus.req0_data = data ^ 16'h0001;
        end
        lat = 0;
        while (bus.res_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (bus.res_valid !== 1'b1) tmo = 1'b1;
        got_id  = bus.res_id;
        got_par = bus.res_parity;
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        aresetn        = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req0_data  = 16'h0000;
        bus.req1_data  = 16'h0000;
        bus.res_ready  = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.req0_ready !== 1'b0) begin n_bad++; $display("FAIL reset_req0_ready: got %b want 0", bus.req0_ready); end
        n_cmp++; if (bus.req1_ready !== 1'b0) begin n_bad++; $display("FAIL reset_req1_ready: got %b want 0", bus.req1_ready); end
        n_cmp++; if (bus.res_valid !== 1'b0) begin n_bad++; $display("FAIL reset_res_valid: got %b want 0", bus.res_valid); end
        n_cmp++; if (bus.res_count !== 8'd0) begin n_bad++; $display("FAIL reset_res_count: got %0d want 0", bus.res_count); end
        n_cmp++; if (bus.res_id !== 1'b0 || bus.res_parity !== 1'b0) begin n_bad++; $display("FAIL reset_res_fields: got id=%b par=%b want 0 0", bus.res_id, bus.res_parity); end
        aresetn = 1'b1;
        #1;
        n_cmp++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin n_bad++; $display("FAIL reset_first_grant: got r0=%b r1=%b want 1 0", bus.req0_ready, bus.req1_ready); end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        do_reset();
    endtask

    task automatic test_single();
        logic [15:0] vec [4] = '{16'h0001, 16'h8421, 16'h0007, 16'hFFFF};
        bit          expp[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        int lat; bit gid, gpar, tmo;
        for (int i = 0; i < 4; i++) begin
            run_txn(1'b0, vec[i], i == 2, lat, gid, gpar, tmo);
            n_cmp++; if (tmo) begin n_bad++; $display("FAIL single_timeout[%0d]: got timeout want completion", i); end
            n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL single_latency[%0d]: got %0d want 4", i, lat); end
            n_cmp++; if (gid !== 1'b0) begin n_bad++; $display("FAIL single_id[%0d]: got %b want 0", i, gid); end
            n_cmp++; if (gpar !== expp[i]) begin n_bad++; $display("FAIL single_parity[%0d]: got %b want %b", i, gpar, expp[i]); end
            n_cmp++; if (bus.res_valid !== 1'b0) begin n_bad++; $display("FAIL single_valid_drop[%0d]: got %b want 0", i, bus.res_valid); end
            n_cmp++; if (bus.res_count !== 8'(i + 1)) begin n_bad++; $display("FAIL single_count[%0d]: got %0d want %0d", i, bus.res_count, i + 1); end
            n_cmp++; if (bus.res_parity !== expp[i]) begin n_bad++; $display("FAIL single_parity_hold[%0d]: got %b want %b", i, bus.res_parity, expp[i]); end
        end
    endtask

    task automatic test_contention();
        bit grants[8];
        int gcyc[8];
        int ng = 0;
        bit both = 1'b0;
        do_reset();
        @(negedge clk);
        bus.req0_data  = 16'h0001;
        bus.req1_data  = 16'h0003;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.res_ready  = 1'b1;
        for (int n = 0; n < 26; n++) begin
            #1;
            if (bus.req0_ready === 1'b1 && bus.req1_ready === 1'b1) both = 1'b1;
            if (bus.res_valid === 1'b1 && ng > 0) begin
                n_cmp++; if (bus.res_id !== grants[ng-1]) begin n_bad++; $display("FAIL cont_res_id@%0d: got %b want %b", n, bus.res_id, grants[ng-1]); end
                n_cmp++; if (bus.res_parity !== !grants[ng-1]) begin n_bad++; $display("FAIL cont_parity@%0d: got %b want %b", n, bus.res_parity, !grants[ng-1]); end
                n_cmp++; if (bus.res_count !== 8'(ng - 1)) begin n_bad++; $display("FAIL cont_count@%0d: got %0d want %0d", n, bus.res_count, ng - 1); end
            end
            if (ng < 8 && (bus.req0_ready === 1'b1 || bus.req1_ready === 1'b1)) begin
                grants[ng] = bus.req1_ready;
                gcyc[ng]   = n;
                ng++;
            end
            @(negedge clk);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        repeat (8) @(negedge clk);
        n_cmp++; if (both) begin n_bad++; $display("FAIL cont_both_ready: got both high want never"); end
        n_cmp++; if (ng !== 5) begin n_bad++; $display("FAIL cont_grant_count: got %0d want 5", ng); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (grants[i] !== i[0]) begin n_bad++; $display("FAIL cont_order[%0d]: got %b want %b", i, grants[i], i[0]); end
        end
        for (int i = 1; i < 4; i++) begin
            n_cmp++; if (gcyc[i] - gcyc[i-1] !== 6) begin n_bad++; $display("FAIL cont_spacing[%0d]: got %0d want 6", i, gcyc[i] - gcyc[i-1]); end
        end
        n_cmp++; if (bus.res_count !== 8'd5) begin n_bad++; $display("FAIL cont_final_count: got %0d want 5", bus.res_count); end
    endtask

    task automatic test_backpressure();
        int w = 0;
        @(negedge clk);
        bus.res_ready  = 1'b0;
        bus.req1_data  = 16'h0310;
        bus.req1_valid = 1'b1;
        #1;
        while (bus.req1_ready !== 1'b1 && w < 20) begin @(negedge clk); #1; w++; end
        n_cmp++; if (bus.req1_ready !== 1'b1) begin n_bad++; $display("FAIL bp_accept: got ready1=%b want 1", bus.req1_ready); end
        @(negedge clk);
        bus.req1_valid = 1'b0;
        w = 0;
        while (bus.res_valid !== 1'b1 && w < 20) begin @(negedge clk); w++; end
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++; if (bus.res_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid[%0d]: got %b want 1", c, bus.res_valid); end
            n_cmp++; if (bus.res_id !== 1'b1 || bus.res_parity !== 1'b1) begin n_bad++; $display("FAIL bp_fields[%0d]: got id=%b par=%b want 1 1", c, bus.res_id, bus.res_parity); end
            n_cmp++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready[%0d]: got r0=%b r1=%b want 0 0", c, bus.req0_ready, bus.req1_ready); end
            n_cmp++; if (bus.res_count !== 8'd5) begin n_bad++; $display("FAIL bp_count[%0d]: got %0d want 5", c, bus.res_count); end
            @(negedge clk);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.res_ready  = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        n_cmp++; if (bus.res_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release_valid: got %b want 0", bus.res_valid); end
        n_cmp++; if (bus.res_count !== 8'd6) begin n_bad++; $display("FAIL bp_release_count: got %0d want 6", bus.res_count); end
        n_cmp++; if (bus.res_id !== 1'b1 || bus.res_parity !== 1'b1) begin n_bad++; $display("FAIL bp_hold_after: got id=%b par=%b want 1 1", bus.res_id, bus.res_parity); end
    endtask

    task automatic test_mid_reset();
        bit leaked = 1'b0;
        int lat; bit gid, gpar, tmo;
        @(negedge clk);
        bus.req0_data  = 16'h0001;
        bus.req0_valid = 1'b1;
        #1;
        n_cmp++; if (bus.req0_ready !== 1'b1) begin n_bad++; $display("FAIL mid_accept: got ready0=%b want 1", bus.req0_ready); end
        @(negedge clk);
        bus.req0_valid = 1'b0;
        @(negedge clk);
        aresetn        = 1'b0;
        bus.req0_valid = 1'b1;
        #1;
        n_cmp++; if (bus.res_valid !== 1'b0 || bus.res_count !== 8'd0) begin n_bad++; $display("FAIL mid_reset_state: got valid=%b count=%0d want 0 0", bus.res_valid, bus.res_count); end
        n_cmp++; if (bus.req0_ready !== 1'b0) begin n_bad++; $display("FAIL mid_reset_ready: got %b want 0", bus.req0_ready); end
        bus.req0_valid = 1'b0;
        @(negedge clk);
        aresetn = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (bus.res_valid === 1'b1) leaked = 1'b1;
            @(negedge clk);
        end
        n_cmp++; if (leaked) begin n_bad++; $display("FAIL mid_no_result: got res_valid=1 want 0"); end
        n_cmp++; if (bus.res_count !== 8'd0) begin n_bad++; $display("FAIL mid_count: got %0d want 0", bus.res_count); end
        run_txn(1'b1, 16'h0007, 1'b0, lat, gid, gpar, tmo);
        n_cmp++; if (tmo || lat !== 4) begin n_bad++; $display("FAIL mid_next_latency: got %0d tmo=%b want 4", lat, tmo); end
        n_cmp++; if (gid !== 1'b1 || gpar !== 1'b1) begin n_bad++; $display("FAIL mid_next_result: got id=%b par=%b want 1 1", gid, gpar); end
        n_cmp++; if (bus.res_count !== 8'd1) begin n_bad++; $display("FAIL mid_next_count: got %0d want 1", bus.res_count); end
    endtask

    task automatic test_wrap();
        int lat; bit gid, gpar, tmo;
        logic [15:0] d;
        do_reset();
        for (int i = 0; i < 255; i++) begin
            d = 16'(i * 16'h1357);
            run_txn(1'b0, d, 1'b0, lat, gid, gpar, tmo);
            n_cmp++; if (tmo || gpar !== ^d) begin n_bad++; $display("FAIL wrap_parity[%0d]: data=%h got %b want %b tmo=%b", i, d, gpar, ^d, tmo); end
        end
        n_cmp++; if (bus.res_count !== 8'd255) begin n_bad++; $display("FAIL wrap_count_255: got %0d want 255", bus.res_count); end
        run_txn(1'b0, 16'h0001, 1'b1, lat, gid, gpar, tmo);
        n_cmp++; if (tmo || gpar !== 1'b1) begin n_bad++; $display("FAIL wrap_toggle_parity: got %b want 1 tmo=%b", gpar, tmo); end
        n_cmp++; if (bus.res_count !== 8'd0) begin n_bad++; $display("FAIL wrap_count_0: got %0d want 0", bus.res_count); end
    endtask

    initial begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_data  = '0;
        bus.req1_data  = '0;
        bus.res_ready  = 1'b0;
        aresetn        = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_mid_reset();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
